// File: rtl/mpu_temp_processor.sv
// Raw TEMP_OUT sample to signed centi-degC converter with a serial shift-add multiplier,
// a power-of-two moving average and a hysteretic over-temperature alarm.
module mpu_temp_processor #(
  parameter int                 AVG_LOG2  = 3,
  parameter logic signed [15:0] HI_THRESH = 16'sd4000,
  parameter logic signed [15:0] HYST      = 16'sd200,
  parameter logic        [15:0] K_SCALE   = 16'd19629
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic signed [15:0] i_raw,
  input  logic               i_raw_valid,
  output logic signed [15:0] o_temp_centi,
  output logic signed [15:0] o_temp_avg,
  output logic               o_temp_valid,
  output logic               o_alarm,
  output logic               o_busy,
  output logic        [7:0]  o_drop_cnt
);

  localparam int                 DEPTH     = 1 << AVG_LOG2;
  localparam int                 SUM_W     = 16 + AVG_LOG2;
  localparam logic signed [15:0] LO_THRESH = HI_THRESH - HYST;

  // Handshake: i_raw is taken on any cycle where i_raw_valid=1 and o_busy=0; a pulse while
  // o_busy=1 is dropped and counted. o_temp_valid is a single-cycle pulse with no back-pressure.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    CALC = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic        [3:0]       iter;
  logic        [15:0]      mag;
  logic                    neg;
  logic        [31:0]      acc;
  logic signed [15:0]      win [DEPTH];
  logic [AVG_LOG2-1:0]     wr_ptr;
  logic                    win_full;
  logic signed [SUM_W-1:0] sum;

  logic signed [31:0]      product;
  logic signed [15:0]      temp_new;
  logic signed [SUM_W-1:0] sum_new;
  logic signed [15:0]      avg_new;

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_raw_valid) state_nxt = MULT;
      MULT:    if (iter == 4'd15) state_nxt = CALC;
      CALC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Offset 2100 is 21.00 C; the shift floors toward -inf on negative products.
  always_comb begin
    product  = neg ? -$signed(acc) : $signed(acc);
    temp_new = 16'(32'sd2100 + (product >>> 16));
    if (!win_full) sum_new = SUM_W'(temp_new) <<< AVG_LOG2;
    else           sum_new = sum - SUM_W'(win[wr_ptr]) + SUM_W'(temp_new);
    avg_new  = 16'(sum_new >>> AVG_LOG2);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      iter         <= '0;
      mag          <= '0;
      neg          <= 1'b0;
      acc          <= '0;
      wr_ptr       <= '0;
      win_full     <= 1'b0;
      sum          <= '0;
      o_temp_centi <= '0;
      o_temp_avg   <= '0;
      o_temp_valid <= 1'b0;
      o_alarm      <= 1'b0;
      o_drop_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
    end else begin
      o_temp_valid <= 1'b0;
      if (i_raw_valid && (state != IDLE) && (o_drop_cnt != 8'hFF))
        o_drop_cnt <= o_drop_cnt + 8'd1;
      case (state)
        IDLE: begin
          if (i_raw_valid) begin
            neg  <= i_raw[15];
            mag  <= i_raw[15] ? $unsigned(-i_raw) : $unsigned(i_raw);
            acc  <= '0;
            iter <= '0;
          end
        end
        MULT: begin
          if (mag[iter]) acc <= acc + (32'(K_SCALE) << iter);
          iter <= iter + 4'd1;
        end
        CALC: begin
          o_temp_centi <= temp_new;
          o_temp_avg   <= avg_new;
          o_temp_valid <= 1'b1;
          sum          <= sum_new;
          // An empty window is prefilled so the average starts at the first reading.
          if (!win_full) begin
            for (int i = 0; i < DEPTH; i++) win[i] <= temp_new;
            win_full <= 1'b1;
          end else begin
            win[wr_ptr] <= temp_new;
            wr_ptr      <= wr_ptr + AVG_LOG2'(1);
          end
          if (avg_new >= HI_THRESH)      o_alarm <= 1'b1;
          else if (avg_new <= LO_THRESH) o_alarm <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_temp_processor.sv
// Bench for mpu_temp_processor: directed scenarios plus random samples, with a
// result scoreboard fed from a behavioural conversion/average/alarm model.
module tb_mpu_temp_processor;

  logic               i_Clk;
  logic               i_Rst_L;
  logic signed [15:0] i_raw;
  logic               i_raw_valid;
  logic signed [15:0] o_temp_centi;
  logic signed [15:0] o_temp_avg;
  logic               o_temp_valid;
  logic               o_alarm;
  logic               o_busy;
  logic        [7:0]  o_drop_cnt;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // {temp_centi, temp_avg, alarm}
  logic [32:0] exp_q[$];

  logic signed [15:0] m_win [8];
  int                 m_ptr;
  bit                 m_full;
  int                 m_sum;
  bit                 m_alarm;

  mpu_temp_processor dut (
    .i_Clk        (i_Clk),
    .i_Rst_L      (i_Rst_L),
    .i_raw        (i_raw),
    .i_raw_valid  (i_raw_valid),
    .o_temp_centi (o_temp_centi),
    .o_temp_avg   (o_temp_avg),
    .o_temp_valid (o_temp_valid),
    .o_alarm      (o_alarm),
    .o_busy       (o_busy),
    .o_drop_cnt   (o_drop_cnt)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  function automatic logic signed [15:0] model_temp(input logic [15:0] raw);
    longint p;
    p = longint'($signed(raw)) * 64'sd19629;
    return 16'(64'sd2100 + (p >>> 16));
  endfunction

  task automatic model_reset();
    m_full  = 1'b0;
    m_ptr   = 0;
    m_sum   = 0;
    m_alarm = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_push(input logic [15:0] raw);
    logic signed [15:0] t;
    logic signed [15:0] a;
    t = model_temp(raw);
    if (!m_full) begin
      for (int i = 0; i < 8; i++) m_win[i] = t;
      m_sum  = 8 * int'(t);
      m_full = 1'b1;
    end else begin
      m_sum        = m_sum - int'(m_win[m_ptr]) + int'(t);
      m_win[m_ptr] = t;
      m_ptr        = (m_ptr + 1) % 8;
    end
    a = 16'(m_sum >>> 3);
    if (a >= 16'sd4000)      m_alarm = 1'b1;
    else if (a <= 16'sd3800) m_alarm = 1'b0;
    exp_q.push_back({t, a, m_alarm});
  endtask

  // Scoreboard: every result pulse must match the oldest pending expectation.
  always @(negedge i_Clk) begin
    logic [32:0] e;
    if (i_Rst_L && o_temp_valid) begin
      assert_cnt++;
      if (exp_q.size() == 0) begin
        fail_cnt++;
        $display("FAIL unexpected_result: got temp=%0d avg=%0d alarm=%0d, none expected",
                 o_temp_centi, o_temp_avg, o_alarm);
      end else begin
        e = exp_q.pop_front();
        if ({o_temp_centi, o_temp_avg, o_alarm} !== e) begin
          fail_cnt++;
          $display("FAIL result: got temp=%0d avg=%0d alarm=%0d, expected temp=%0d avg=%0d alarm=%0d",
                   o_temp_centi, o_temp_avg, o_alarm,
                   $signed(e[32:17]), $signed(e[16:1]), e[0]);
        end
      end
    end
  end

  task automatic do_reset();
    i_Rst_L     = 1'b0;
    i_raw_valid = 1'b0;
    i_raw       = '0;
    model_reset();
    repeat (2) @(posedge i_Clk);
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
  endtask

  task automatic send(input logic [15:0] raw);
    int n;
    n = 0;
    while (o_busy && n < 40) begin
      @(posedge i_Clk); #1;
      n++;
    end
    if (o_busy) begin
      assert_cnt++; fail_cnt++;
      $display("FAIL send_timeout: busy=%0d, required 0", o_busy);
    end
    i_raw       = raw;
    i_raw_valid = 1'b1;
    model_push(raw);
    @(posedge i_Clk); #1;
    i_raw_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge i_Clk); #1;
      lat++;
    end while (!o_temp_valid && lat < 40);
    if (!o_temp_valid) begin
      assert_cnt++; fail_cnt++;
      $display("FAIL result_timeout: valid=%0d after %0d cycles, required 1", o_temp_valid, lat);
    end
  endtask

  task automatic test_reset();
    int lat;
    do_reset();
    assert_cnt++;
    if ({o_temp_centi, o_temp_avg, o_temp_valid, o_alarm, o_busy, o_drop_cnt} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_outputs: temp=%0d avg=%0d valid=%0d alarm=%0d busy=%0d drop=%0d, required all 0",
               o_temp_centi, o_temp_avg, o_temp_valid, o_alarm, o_busy, o_drop_cnt);
    end
    send(16'h0190);
    assert_cnt++;
    if (o_busy !== 1'b1) begin
      fail_cnt++; $display("FAIL busy_after_accept: got %0d, required 1", o_busy);
    end
    wait_result(lat);
    assert_cnt++;
    if (lat != 17) begin
      fail_cnt++; $display("FAIL latency: got %0d edges after sample edge, required 17", lat);
    end
    assert_cnt++;
    if (o_temp_centi !== 16'sd2219 || o_temp_avg !== 16'sd2219 || o_alarm !== 1'b0 || o_drop_cnt !== 8'd0) begin
      fail_cnt++;
      $display("FAIL first_sample: temp=%0d avg=%0d alarm=%0d drop=%0d, required 2219 2219 0 0",
               o_temp_centi, o_temp_avg, o_alarm, o_drop_cnt);
    end
    assert_cnt++;
    if (o_busy !== 1'b0) begin
      fail_cnt++; $display("FAIL busy_at_valid: got %0d, required 0", o_busy);
    end
  endtask

  task automatic test_range();
    int lat;
    send(16'h8000);
    wait_result(lat);
    assert_cnt++;
    if (o_temp_centi !== 16'shE1DD) begin
      fail_cnt++; $display("FAIL range_min: got %0d, required -7715", o_temp_centi);
    end
    do_reset();
    send(16'h7FFF);
    wait_result(lat);
    assert_cnt++;
    if (o_temp_centi !== 16'sh2E8A || o_temp_avg !== 16'sh2E8A) begin
      fail_cnt++;
      $display("FAIL range_max: temp=%0d avg=%0d, required 11914 11914", o_temp_centi, o_temp_avg);
    end
  endtask

  task automatic test_averaging();
    int lat;
    do_reset();
    send(16'h0000);
    wait_result(lat);
    assert_cnt++;
    if (o_temp_centi !== 16'sd2100 || o_temp_avg !== 16'sd2100) begin
      fail_cnt++;
      $display("FAIL avg_prefill: temp=%0d avg=%0d, required 2100 2100", o_temp_centi, o_temp_avg);
    end
    send(16'h0190);
    wait_result(lat);
    assert_cnt++;
    if (o_temp_centi !== 16'sd2219 || o_temp_avg !== 16'sd2114) begin
      fail_cnt++;
      $display("FAIL avg_step: temp=%0d avg=%0d, required 2219 2114", o_temp_centi, o_temp_avg);
    end
    for (int i = 0; i < 8; i++) begin
      send(16'h0190);
      wait_result(lat);
    end
    assert_cnt++;
    if (o_temp_avg !== 16'sd2219) begin
      fail_cnt++; $display("FAIL avg_settle: got %0d, required 2219", o_temp_avg);
    end
  endtask

  task automatic test_alarm();
    int lat;
    do_reset();
    send(16'h18C8);
    wait_result(lat);
    assert_cnt++;
    if (o_alarm !== 1'b1 || o_temp_avg !== 16'sd4000) begin
      fail_cnt++; $display("FAIL alarm_set: alarm=%0d avg=%0d, required 1 4000", o_alarm, o_temp_avg);
    end
    for (int i = 0; i < 7; i++) begin
      send(16'h162C);
      wait_result(lat);
    end
    assert_cnt++;
    if (o_alarm !== 1'b1 || o_temp_avg !== 16'sd3825) begin
      fail_cnt++; $display("FAIL alarm_hold: alarm=%0d avg=%0d, required 1 3825", o_alarm, o_temp_avg);
    end
    send(16'h162C);
    wait_result(lat);
    assert_cnt++;
    if (o_alarm !== 1'b0 || o_temp_avg !== 16'sd3800) begin
      fail_cnt++; $display("FAIL alarm_clear: alarm=%0d avg=%0d, required 0 3800", o_alarm, o_temp_avg);
    end
  endtask

  task automatic test_overrun();
    int lat;
    do_reset();
    send(16'h0190);
    repeat (4) @(posedge i_Clk);
    #1;
    i_raw       = 16'h7000;
    i_raw_valid = 1'b1;
    @(posedge i_Clk); #1;
    i_raw_valid = 1'b0;
    wait_result(lat);
    assert_cnt++;
    if (o_drop_cnt !== 8'd1 || o_temp_centi !== 16'sd2219) begin
      fail_cnt++;
      $display("FAIL overrun_single: drop=%0d temp=%0d, required 1 2219", o_drop_cnt, o_temp_centi);
    end
    // Held valid: accepted every 18th edge, the rest are drops (306 in total).
    @(posedge i_Clk); #1;
    i_raw       = 16'h0320;
    i_raw_valid = 1'b1;
    for (int i = 0; i < 18; i++) model_push(16'h0320);
    repeat (324) @(posedge i_Clk);
    #1;
    i_raw_valid = 1'b0;
    repeat (25) @(posedge i_Clk);
    #1;
    assert_cnt++;
    if (o_drop_cnt !== 8'd255) begin
      fail_cnt++; $display("FAIL drop_saturate: got %0d, required 255", o_drop_cnt);
    end
    assert_cnt++;
    if (exp_q.size() != 0) begin
      fail_cnt++; $display("FAIL continuous_results: %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_conversion();
    int lat;
    do_reset();
    send(16'h18C8);
    wait_result(lat);
    send(16'h0190);
    repeat (10) @(posedge i_Clk);
    #1;
    i_Rst_L = 1'b0;
    model_reset();
    #1;
    assert_cnt++;
    if ({o_temp_centi, o_temp_avg, o_temp_valid, o_alarm, o_busy, o_drop_cnt} !== '0) begin
      fail_cnt++;
      $display("FAIL midreset_outputs: temp=%0d avg=%0d valid=%0d alarm=%0d busy=%0d drop=%0d, required all 0",
               o_temp_centi, o_temp_avg, o_temp_valid, o_alarm, o_busy, o_drop_cnt);
    end
    repeat (3) @(posedge i_Clk);
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    repeat (25) @(posedge i_Clk);
    #1;
    assert_cnt++;
    if (o_temp_valid !== 1'b0 || o_busy !== 1'b0) begin
      fail_cnt++; $display("FAIL midreset_idle: valid=%0d busy=%0d, required 0 0", o_temp_valid, o_busy);
    end
    send(16'h162C);
    wait_result(lat);
    assert_cnt++;
    if (o_temp_avg !== 16'sd3800 || o_alarm !== 1'b0) begin
      fail_cnt++; $display("FAIL midreset_refill: avg=%0d alarm=%0d, required 3800 0", o_temp_avg, o_alarm);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send(16'($urandom_range(0, 65535)));
      wait_result(lat);
    end
    assert_cnt++;
    if (o_drop_cnt !== 8'd0) begin
      fail_cnt++; $display("FAIL back_to_back_drops: got %0d, required 0", o_drop_cnt);
    end
  endtask

  initial begin
    i_Rst_L     = 1'b0;
    i_raw       = '0;
    i_raw_valid = 1'b0;
    test_reset();
    test_range();
    test_averaging();
    test_alarm();
    test_overrun();
    test_reset_mid_conversion();
    test_back_to_back();
    repeat (5) @(posedge i_Clk);
    #1;
    assert_cnt++;
    if (exp_q.size() != 0) begin
      fail_cnt++; $display("FAIL scoreboard_drain: %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
